// File: rtl/arm_multicycle_datapath_if.sv
// Unified memory port of arm_multicycle_datapath: one req/ready handshake
// shared by instruction fetch and data access.
interface arm_multicycle_datapath_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/arm_multicycle_datapath.sv
// Multicycle ARM-subset core (DP/LDR/STR/B) with unified memory port and bus timeout.
// Optional macro COND_EXEC_EN enables condition-code evaluation in DECODE.
module arm_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          WAIT_MAX = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  arm_multicycle_datapath_if.master        mem,
  output logic [31:0]                      PC,
  output logic [31:0]                      Instruction,
  output logic [3:0]                       ALUFlags,
  output logic [2:0]                       state,
  output logic                             fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [3:0]  CMD_AND   = 4'b0000;
  localparam logic [3:0]  CMD_SUB   = 4'b0010;
  localparam logic [3:0]  CMD_ADD   = 4'b0100;
  localparam logic [3:0]  CMD_CMP   = 4'b1010;
  localparam logic [3:0]  CMD_ORR   = 4'b1100;
  localparam logic [31:0] WAIT_LAST = 32'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d;
  logic [31:0]       rf_q [0:14];
  logic [31:0]       rf_d [0:14];
  logic [3:0]        flags_q, flags_d;
  logic [31:0]       a_q, a_d, b_q, b_d, alu_q, alu_d, data_q, data_d;
  logic              req_q, req_d, we_q, we_d, fault_q, fault_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, wait_q, wait_d;

  logic [1:0]  op;
  logic [3:0]  cmd, rn, rd, rm;
  logic        imm_i, s_bit, u_bit;
  logic [31:0] imm8_ext, imm_ror, src_b, alu_res, wb_val;
  logic [32:0] sum33, diff33;
  logic        res_c, res_v, dp_ok, op_ok, is_cmp, issue_fetch, issue_mem;

  assign op    = ir_q[27:26];
  assign imm_i = ir_q[25];
  assign cmd   = ir_q[24:21];
  assign u_bit = ir_q[23];
  assign s_bit = ir_q[20];
  assign rn    = ir_q[19:16];
  assign rd    = ir_q[15:12];
  assign rm    = ir_q[3:0];
  assign is_cmp = (cmd == CMD_CMP);
  assign dp_ok  = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                  (cmd == CMD_ORR) || is_cmp;
  assign op_ok  = (op == 2'b01) || (op == 2'b10) || ((op == 2'b00) && dp_ok);

`ifdef COND_EXEC_EN
  logic cond_ok;
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    case (ir_q[31:28])
      4'h0:    cond_ok = z;
      4'h1:    cond_ok = !z;
      4'h2:    cond_ok = c;
      4'h3:    cond_ok = !c;
      4'h4:    cond_ok = n;
      4'h5:    cond_ok = !n;
      4'h6:    cond_ok = v;
      4'h7:    cond_ok = !v;
      4'h8:    cond_ok = c && !z;
      4'h9:    cond_ok = !c || z;
      4'hA:    cond_ok = (n == v);
      4'hB:    cond_ok = (n != v);
      4'hC:    cond_ok = !z && (n == v);
      4'hD:    cond_ok = z || (n != v);
      default: cond_ok = 1'b1;
    endcase
  end
`endif

  // Operand B: rotated imm8 or Rm for DP, zero-extended imm12 for LDR/STR, word offset for B
  always_comb begin
    imm8_ext = {24'h0, ir_q[7:0]};
    imm_ror  = (imm8_ext >> {ir_q[11:8], 1'b0}) |
               (imm8_ext << (6'd32 - {1'b0, ir_q[11:8], 1'b0}));
    case (op)
      2'b00:   src_b = imm_i ? imm_ror : b_q;
      2'b01:   src_b = {20'h0, ir_q[11:0]};
      default: src_b = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
    endcase
    sum33  = {1'b0, a_q} + {1'b0, src_b};
    diff33 = {1'b0, a_q} - {1'b0, src_b};
    res_c  = flags_q[1];
    res_v  = flags_q[0];
    alu_res = sum33[31:0];
    if (op == 2'b00) begin
      case (cmd)
        CMD_ADD: begin
          res_c = sum33[32];
          res_v = (a_q[31] == src_b[31]) && (sum33[31] != a_q[31]);
        end
        CMD_SUB, CMD_CMP: begin
          alu_res = diff33[31:0];
          res_c   = ~diff33[32];
          res_v   = (a_q[31] != src_b[31]) && (diff33[31] != a_q[31]);
        end
        CMD_AND: alu_res = a_q & src_b;
        default: alu_res = a_q | src_b;
      endcase
    end else if ((op == 2'b01) && !u_bit) begin
      alu_res = diff33[31:0];
    end
  end

  always_comb begin
    state_d = state_q;  pc_d    = pc_q;    ir_d    = ir_q;
    rf_d    = rf_q;     flags_d = flags_q; a_d     = a_q;
    b_d     = b_q;      alu_d   = alu_q;   data_d  = data_q;
    req_d   = req_q;    we_d    = we_q;    addr_d  = addr_q;
    wdata_d = wdata_q;  wait_d  = wait_q;  fault_d = fault_q;
    issue_fetch = 1'b0;
    issue_mem   = 1'b0;
    wb_val      = (op == 2'b01) ? data_q : alu_q;

    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          issue_fetch = 1'b1;
        end else if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + 32'd4;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // pc_q already points past this instruction, so R15 reads as PC+4 = address+8
        a_d = (rn == 4'd15 || op == 2'b10) ? pc_q + 32'd4 : rf_q[rn];
        if (op == 2'b01 && !s_bit)
          b_d = (rd == 4'd15) ? pc_q + 32'd4 : rf_q[rd];
        else
          b_d = (rm == 4'd15) ? pc_q + 32'd4 : rf_q[rm];
`ifdef COND_EXEC_EN
        if (!cond_ok) issue_fetch = 1'b1;
        else
`endif
        if (!op_ok) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (op == 2'b00 && (s_bit || is_cmp))
          flags_d = {alu_res[31], alu_res == 32'h0, res_c, res_v};
        if (op == 2'b01) issue_mem = 1'b1;
        else             state_d   = S_WB;
      end
      S_MEM: begin
        if (req_q && mem.mem_ready) begin
          req_d = 1'b0;
          if (we_q) begin
            issue_fetch = 1'b1;
          end else begin
            data_d  = mem.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (op == 2'b10 || rd == 4'd15) begin
          if (!(op == 2'b00 && is_cmp)) pc_d = wb_val;
        end else if (!(op == 2'b00 && is_cmp)) begin
          rf_d[rd] = wb_val;
        end
        issue_fetch = 1'b1;
      end
      default: begin
        req_d   = 1'b0;
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    endcase

    if (req_q && !mem.mem_ready && WAIT_MAX != 0) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_FAULT;
        req_d   = 1'b0;
        fault_d = 1'b1;
      end else begin
        wait_d = wait_q + 32'd1;
      end
    end

    if (issue_fetch) begin
      req_d   = 1'b1;
      we_d    = 1'b0;
      addr_d  = pc_d[ADDR_W-1:0];
      wait_d  = '0;
      state_d = S_FETCH;
    end else if (issue_mem) begin
      req_d   = 1'b1;
      we_d    = ~s_bit;
      addr_d  = alu_d[ADDR_W-1:0];
      wdata_d = b_q;
      wait_d  = '0;
      state_d = S_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      for (int unsigned i = 0; i < 15; i++) rf_q[i] <= '0;
      flags_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rf_q    <= rf_d;
      flags_q <= flags_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign PC            = pc_q;
  assign Instruction   = ir_q;
  assign ALUFlags      = flags_q;
  assign state         = state_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_arm_multicycle_datapath.sv
// Scoreboard bench for arm_multicycle_datapath: directed program, expected bus
// transactions queued by the stimulus and popped by an independent monitor.
module tb_arm_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, Instruction;
  logic [3:0]  ALUFlags;
  logic [2:0]  state;
  logic        fault;

  arm_multicycle_datapath_if #(.ADDR_W(32)) bus ();

  arm_multicycle_datapath #(
    .RESET_PC (32'h0000_0100),
    .ADDR_W   (32),
    .WAIT_MAX (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (bus),
    .PC          (PC),
    .Instruction (Instruction),
    .ALUFlags    (ALUFlags),
    .state       (state),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        fetch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  flags;
    int          delta;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          hang_at  = 16;
  int          completions = 0;
  int          stall_run = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic push(input logic we, input logic fetch, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] flags, input int delta);
    exp_t e;
    e.we = we; e.fetch = fetch; e.addr = addr; e.wdata = wdata; e.flags = flags; e.delta = delta;
    sb.push_back(e);
  endtask

  // Memory: read of address 8 takes 3 wait cycles, everything else is zero-wait
  initial begin
    int          stall;
    int          delay;
    logic [31:0] a;
    stall = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      a     = bus.mem_addr;
      delay = (!bus.mem_we && a == 32'h8) ? 3 : 0;
      if (!rst || !bus.mem_req) begin
        bus.mem_ready = 1'b0;
        stall = 0;
      end else if (completions >= hang_at) begin
        bus.mem_ready = 1'b0;
      end else if (stall >= delay) begin
        bus.mem_ready = 1'b1;
        if (bus.mem_we) mem[a[9:2]] = bus.mem_wdata;
        else            bus.mem_rdata = mem[a[9:2]];
        stall = 0;
        completions++;
      end else begin
        bus.mem_ready = 1'b0;
        stall++;
      end
    end
  end

  // Monitor: compare every completed access against the head of the scoreboard
  initial begin
    int          cyc;
    int          last_done;
    logic        prev_stall;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    exp_t        e;
    cyc = 0; last_done = 0; prev_stall = 1'b0;
    prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.mem_req && prev_stall) begin
          check("hold_we", {31'h0, bus.mem_we}, {31'h0, prev_we});
          check("hold_addr", bus.mem_addr, prev_addr);
          check("hold_wdata", bus.mem_wdata, prev_wdata);
        end
        if (bus.mem_req && bus.mem_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_access: got addr %h, expected no access", bus.mem_addr);
          end else begin
            e = sb.pop_front();
            check("acc_we", {31'h0, bus.mem_we}, {31'h0, e.we});
            check("acc_addr", bus.mem_addr, e.addr);
            if (e.we) check("acc_wdata", bus.mem_wdata, e.wdata);
            if (e.fetch) begin
              check("fetch_pc", PC, e.addr);
              check("fetch_flags", {28'h0, ALUFlags}, {28'h0, e.flags});
            end
            if (e.delta >= 0) check("acc_cycles", 32'(cyc - last_done), 32'(e.delta));
          end
          last_done  = cyc;
          stall_run  = 0;
          prev_stall = 1'b0;
        end else if (bus.mem_req) begin
          stall_run++;
          prev_stall = 1'b1;
          prev_we    = bus.mem_we;
          prev_addr  = bus.mem_addr;
          prev_wdata = bus.mem_wdata;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  task automatic wait_fault();
    for (int i = 0; i < 400 && !fault; i++) @(negedge clk);
    #3;
  endtask

  task automatic check_reset_state();
    check("rst_state", {29'h0, state}, 32'h0);
    check("rst_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_pc", PC, 32'h100);
    check("rst_ir", Instruction, 32'h0);
    check("rst_flags", {28'h0, ALUFlags}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[32'h100 >> 2] = 32'hE250_3001;  // SUBS r3, r0, #1
    mem[32'h104 >> 2] = 32'hE380_10FF;  // ORR  r1, r0, #0xFF
    mem[32'h108 >> 2] = 32'hE291_2001;  // ADDS r2, r1, #1
    mem[32'h10C >> 2] = 32'hE580_2008;  // STR  r2, [r0, #8]
    mem[32'h110 >> 2] = 32'hE590_4008;  // LDR  r4, [r0, #8]
    mem[32'h114 >> 2] = 32'hE580_400C;  // STR  r4, [r0, #0xC]
    mem[32'h118 >> 2] = 32'hE580_3010;  // STR  r3, [r0, #0x10]
    mem[32'h11C >> 2] = 32'hEAFF_FFBF;  // B    0x20
    mem[32'h020 >> 2] = 32'hE150_0000;  // CMP  r0, r0
    mem[32'h024 >> 2] = 32'h1A00_0001;  // BNE  0x30
    mem[32'h028 >> 2] = 32'hEAFF_FFFE;  // B    0x28
    mem[32'h030 >> 2] = 32'hEAFF_FFFE;  // B    0x30

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check_reset_state();

    push(0, 1, 32'h100, 0, 4'b0000, -1);
    push(0, 1, 32'h104, 0, 4'b1000, 4);
    push(0, 1, 32'h108, 0, 4'b1000, 4);
    push(0, 1, 32'h10C, 0, 4'b0000, 4);
    push(1, 0, 32'h008, 32'h100, 0, 3);
    push(0, 1, 32'h110, 0, 4'b0000, 1);
    push(0, 0, 32'h008, 0, 0, 6);
    push(0, 1, 32'h114, 0, 4'b0000, 2);
    push(1, 0, 32'h00C, 32'h100, 0, 3);
    push(0, 1, 32'h118, 0, 4'b0000, 1);
    push(1, 0, 32'h010, 32'hFFFF_FFFF, 0, 3);
    push(0, 1, 32'h11C, 0, 4'b0000, 1);
    push(0, 1, 32'h020, 0, 4'b0000, 4);
    push(0, 1, 32'h024, 0, 4'b0110, 4);
`ifdef COND_EXEC_EN
    push(0, 1, 32'h028, 0, 4'b0110, 2);
    push(0, 1, 32'h028, 0, 4'b0110, 4);
`else
    push(0, 1, 32'h030, 0, 4'b0110, 4);
    push(0, 1, 32'h030, 0, 4'b0110, 4);
`endif

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("first_req", {31'h0, bus.mem_req}, 32'h1);
    check("first_addr", bus.mem_addr, 32'h100);
    @(negedge clk);
    #3;
    check("pc_after_fetch", PC, 32'h104);
    check("state_decode", {29'h0, state}, 32'h1);

    wait_fault();
    check("timeout_fault", {31'h0, fault}, 32'h1);
    check("timeout_req", {31'h0, bus.mem_req}, 32'h0);
    check("timeout_state", {29'h0, state}, 32'h5);
    check("timeout_waits", 32'(stall_run), 32'd4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    #3;
    check("fault_sticky", {31'h0, fault}, 32'h1);
    check("fault_no_req", {31'h0, bus.mem_req}, 32'h0);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check_reset_state();
    mem[32'h100 >> 2] = 32'hEC00_0000;  // op=11
    hang_at = 1000;
    push(0, 1, 32'h100, 0, 4'b0000, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("rerun_req", {31'h0, bus.mem_req}, 32'h1);
    check("rerun_addr", bus.mem_addr, 32'h100);
    wait_fault();
    check("op11_fault", {31'h0, fault}, 32'h1);
    check("op11_req", {31'h0, bus.mem_req}, 32'h0);
    check("op11_state", {29'h0, state}, 32'h5);
    check("op11_pc", PC, 32'h104);
    check("op11_ir", Instruction, 32'hEC00_0000);
    check("sb_drained2", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arm_multicycle_datapath.md
Name: arm_multicycle_datapath

Overview:
Parametrised multicycle successor to the single-cycle ARM datapath. It pairs a datapath (internal IR, data, A/B and ALUOut registers) with its own control FSM. A single unified memory port with a req/ready handshake serves both instruction fetch and data access, and a configurable bus timeout drives the core into a sticky fault state. It sits between the unified memory or bus arbiter and the equalizer control software.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, width of mem_addr; the low ADDR_W bits of the PC or ALUOut are driven
WAIT_MAX, 16, maximum cycles mem_req may wait for mem_ready; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
mem_req  out  1  memory access request
mem_we  out  1  1 = write (STR), 0 = read
mem_addr  out  ADDR_W  access address
mem_wdata  out  32  store data (Rd value)
mem_rdata  in  32  read data, valid when mem_req && mem_ready
mem_ready  in  1  access completes this cycle
PC  out  32  current PC register
Instruction  out  32  instruction register (IR)
ALUFlags  out  4  stored {N,Z,C,V}
state  out  3  FSM state encoding, for debug
fault  out  1  sticky fault indicator

Behaviour:
- One clock; reset is synchronous and active-low (rst=0 sampled at posedge clk).
- Reset values:
  - PC=RESET_PC, IR=0, r0-r14=0, ALUFlags=0, fault=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - state=FETCH (encoding 0).
  - The first request is issued in the first cycle after rst rises.
- Reset mid-access: mem_req drops at that same edge, and no architectural state is kept from the aborted access.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle in which mem_ready=1; that cycle completes the access.
  - mem_req falls on the following edge.
  - mem_ready is ignored while mem_req=0.
  - A 1-cycle access (mem_ready=1 in the first req cycle) is legal.
- Timeout: a wait counter is cleared at each new request. When it reaches WAIT_MAX with no mem_ready, the FSM goes to FAULT and mem_req drops.
- States:
  - FETCH: req read at PC. On ready, IR<=mem_rdata and PC<=PC+4.
  - DECODE: A<=R[Rn], B<=R[Rm] (or R[Rd] for STR). Reads of R15 return PC+4, i.e. instruction address + 8. Unsupported encodings go to FAULT.
  - EXEC: ALUOut<=ALU(A, SrcB). DP ops optionally update flags. A branch computes PC+4 + sext(imm24)<<2.
  - MEM: LDR reads, or STR writes, at ALUOut. STR returns to FETCH.
  - WB: LDR writes DataReg, DP writes ALUOut, to Rd. Rd=15 or a branch writes PC instead. Then go to FETCH.
  - FAULT: absorbing until reset; fault=1, mem_req=0.
- Cycle counts with zero wait states: DP/B = 4 (FETCH, DECODE, EXEC, WB); STR = 4 (FETCH, DECODE, EXEC, MEM); LDR = 5.
- Decode fields:
  - op = Instr[27:26]: 00 DP, 01 LDR/STR, 10 B, 11 FAULT.
  - DP cmd = Instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (flags always, no write). Any other cmd goes to FAULT.
  - DP with I=1: SrcB = imm8 ROR 2*rot. I=0: SrcB = Rm; shift fields are ignored.
  - S = Instr[20] updates flags for non-CMP ops.
  - LDR/STR: imm12 zero-extended; U = Instr[23] selects add or subtract; L = Instr[20]; no writeback or pre/post variants.
- Flags:
  - ADD: C = carry-out, V = signed overflow.
  - SUB/CMP: C = NOT borrow.
  - AND/ORR: C and V unchanged.
  - N = result[31], Z = (result==0).
- Arithmetic is 32-bit and wraps modulo 2^32. PC increments wrap 32'hFFFF_FFFC -> 0.

Optional Feature:
COND_EXEC_EN
- Defined: Instr[31:28] is evaluated in DECODE against the stored flags (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 = AL). On failure the FSM returns to FETCH, giving 2 cycles after fetch. A failed instruction changes no register, no flag and no memory, and causes no fault, even if its opcode is unsupported.
- Undefined: the cond field is ignored and every instruction executes.

Test Plan:
- Reset with RESET_PC=32'h100, memory ready every cycle -> first mem_addr=32'h100, mem_req=1 on the first cycle after rst rises; PC=32'h104 after FETCH.
- MOV-via-ORR: r1 = r0 ORR #0xFF, then ADDS r2 = r1 + #1 -> r2=32'h100, flags NZCV=0000; each instruction takes 4 cycles.
- SUBS with r3 = 32'h0 minus #1 -> r3=32'hFFFF_FFFF, N=1, Z=0, C=0, V=0.
- STR r2 to [r0,#8], then LDR r4 from [r0,#8] with mem_ready delayed 3 cycles -> mem_we=1 with mem_wdata=32'h100 at addr 8; r4=32'h100; inputs held stable during the wait.
- B -2 (imm24=24'hFFFFFE) at address 0x20 -> next fetch at 0x20 (PC+8-8). CMP r0,r0 followed by BNE with COND_EXEC_EN -> branch not taken, next fetch at branch address +4.
- WAIT_MAX=4 with mem_ready held at 0 -> FAULT after 4 waiting cycles, mem_req=0, fault=1 until rst=0. An op=11 instruction also faults.
